// File: rtl/pipe_add_pkg.sv
// pipe_add_pkg: shared per-stage control type and stage-count helper for pipe_add_n.
package pipe_add_pkg;
    typedef struct packed {logic v; logic c;} stage_ctl_t;
    function automatic int stages_f(int width, int chunk);
        return width / chunk;
    endfunction
endpackage

// File: rtl/pipe_add_n_if.sv
// pipe_add_n_if: operand and result valid/ready bus; ovf exists only with PIPE_ADD_OVF_EN.
interface pipe_add_n_if #(parameter int WIDTH = 32);
    logic in_valid, in_ready, c_in, out_valid, out_ready, c_out;
    logic [WIDTH-1:0] a, b, s;
`ifdef PIPE_ADD_OVF_EN
    logic ovf;
    modport master (output in_valid, a, b, c_in, out_ready, input in_ready, out_valid, s, c_out, ovf);
    modport slave (input in_valid, a, b, c_in, out_ready, output in_ready, out_valid, s, c_out, ovf);
`else
    modport master (output in_valid, a, b, c_in, out_ready, input in_ready, out_valid, s, c_out);
    modport slave (input in_valid, a, b, c_in, out_ready, output in_ready, out_valid, s, c_out);
`endif
endinterface

// File: rtl/pipe_add_n_add_chunk.sv
// add_chunk: combinational W-bit ripple slice; c_msb is the carry into the top bit.
module add_chunk #(parameter int W = 8) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         c_msb
);
    logic [W:0] full;
    assign full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    assign s = full[W-1:0];
    assign co = full[W];
    assign c_msb = full[W-1] ^ a[W-1] ^ b[W-1];
endmodule

// File: rtl/pipe_add_n.sv
// pipe_add_n: pipelined WIDTH-bit adder, one CHUNK-bit carry slice per stage, valid/ready both sides.
// Define PIPE_ADD_OVF_EN to add the registered signed-overflow output.
module pipe_add_n
    import pipe_add_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input logic         clk,
    input logic         reset,
    pipe_add_n_if.slave bus
);
    localparam int STAGES = stages_f(WIDTH, CHUNK);
    if (WIDTH % CHUNK != 0 || STAGES < 1) begin : g_bad
        $error("pipe_add_n: WIDTH must be a positive multiple of CHUNK");
    end
    logic adv;
    stage_ctl_t ctl [STAGES];
    logic [CHUNK-1:0] op_a [STAGES], op_b [STAGES], sum [STAGES], aligned [STAGES];
    logic [STAGES-1:0] co, msb;
    assign adv = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;
    for (genvar k = 0; k < STAGES; k++) begin : g_st
        if (k == 0) begin : g_in
            assign op_a[k] = bus.a[CHUNK-1:0];
            assign op_b[k] = bus.b[CHUNK-1:0];
            assign ctl[k] = '{v: bus.in_valid, c: bus.c_in};
        end else begin : g_skew
            // chunk k operands wait k cycles so they meet the carry from stage k-1
            logic [CHUNK-1:0] da [k], db [k];
            stage_ctl_t q;
            always_ff @(posedge clk or posedge reset)
                if (reset) begin
                    da <= '{default: '0};
                    db <= '{default: '0};
                    q <= '0;
                end else if (adv) begin
                    da[0] <= bus.a[k*CHUNK +: CHUNK];
                    db[0] <= bus.b[k*CHUNK +: CHUNK];
                    for (int j = 1; j < k; j++) begin
                        da[j] <= da[j-1];
                        db[j] <= db[j-1];
                    end
                    q <= '{v: ctl[k-1].v, c: co[k-1]};
                end
            assign op_a[k] = da[k-1];
            assign op_b[k] = db[k-1];
            assign ctl[k] = q;
        end
        add_chunk #(.W(CHUNK)) u_add (
            .a(op_a[k]), .b(op_b[k]), .ci(ctl[k].c),
            .s(sum[k]), .co(co[k]), .c_msb(msb[k])
        );
        if (k == STAGES - 1) begin : g_top
            assign aligned[k] = sum[k];
        end else begin : g_deskew
            logic [CHUNK-1:0] d [STAGES-1-k];
            always_ff @(posedge clk or posedge reset)
                if (reset) d <= '{default: '0};
                else if (adv) begin
                    d[0] <= sum[k];
                    for (int j = 1; j < STAGES - 1 - k; j++) d[j] <= d[j-1];
                end
            assign aligned[k] = d[STAGES-2-k];
        end
    end
    // result registers load only when a valid op lands, so bubbles leave s/c_out untouched
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.s <= '0;
            bus.c_out <= 1'b0;
`ifdef PIPE_ADD_OVF_EN
            bus.ovf <= 1'b0;
`endif
        end else if (adv) begin
            bus.out_valid <= ctl[STAGES-1].v;
            if (ctl[STAGES-1].v) begin
                for (int i = 0; i < STAGES; i++) bus.s[i*CHUNK +: CHUNK] <= aligned[i];
                bus.c_out <= co[STAGES-1];
`ifdef PIPE_ADD_OVF_EN
                bus.ovf <= msb[STAGES-1] ^ co[STAGES-1];
`endif
            end
        end
`ifndef PIPE_ADD_OVF_EN
    logic unused_msb;
    assign unused_msb = ^msb;
`endif
endmodule
